hv_sram_server: RTL and testbench
=================================

# hv_sram_server

Responder side of the spatial encoder's item-memory / projection-matrix read protocol, one instance per modality. It accepts a row address with a valid/ready request handshake and reads the IM, negative projection and positive projection rows from three narrow single-port SRAM macros over several beats. It assembles each row into a full hypervector and returns all three with a valid/ready response handshake. Three instances sit between the SRAM macros and the encoder's per-modality `addr_modN` / `spatial_*` / `sramN_*` / `IMOut_*` / `projM_*` ports.

## Interface
- HV_DIMENSION, `` `HV_DIMENSION `` (2000), hypervector width
- WORD_WIDTH, 200, SRAM macro word width; HV_DIMENSION must be a multiple of it
- BEATS, HV_DIMENSION/WORD_WIDTH (10), reads per row
- ADDR_WIDTH, 8, request address width
- NUM_ENTRIES, 256, valid rows; addresses ≥ NUM_ENTRIES are errors
- MEM_ADDR_WIDTH, 12, macro address width (≥ clog2(NUM_ENTRIES*BEATS))

Ports:
- Clk_CI  in  1  clock, rising edge
- Reset_RI  in  1  reset; asynchronous, active-low
- ReqValid_SI  in  1  request valid (encoder spatial_valid_N)
- ReqAddr_DI  in  ADDR_WIDTH  row address (encoder addr_modN)
- ReqReady_SO  out  1  server can accept a request
- RespReady_SI  in  1  encoder can take the response (spatial_ready_N)
- RespValid_SO  out  3  response valid; bit0 IM, bit1 neg, bit2 pos; always equal (drives sram*_valid)
- IMOut_DO, ProjNeg_DO, ProjPos_DO  out  [0:HV_DIMENSION-1] each  assembled hypervectors
- AddrErr_SO  out  1  current response is for an out-of-range address
- MemRe_SO  out  1  read enable shared by the three macros
- MemAddr_DO  out  MEM_ADDR_WIDTH  shared macro address
- MemIM_DI, MemNeg_DI, MemPos_DI  in  WORD_WIDTH each  macro read data, valid the cycle after MemRe_SO

## Operation
- States: IDLE, READ, DRAIN, RESP.
- IDLE: ReqReady_SO=1. A request is accepted when ReqValid_SI & ReqReady_SO at a rising edge. The server latches ReqAddr_DI and sets AddrErr from (ReqAddr_DI ≥ NUM_ENTRIES).
  - In range: go to READ with beat counter k=0.
  - Out of range: go to READ with reads suppressed; MemRe_SO stays 0.
- READ: one cycle per beat, k = 0..BEATS-1.
  - MemRe_SO=1 (0 on error).
  - MemAddr_DO = addr*BEATS + k, computed at MEM_ADDR_WIDTH with no truncation.
  - When k = BEATS-1, go to DRAIN.
- Capture: the data returned for beat k is written to bits [k*WORD_WIDTH : (k+1)*WORD_WIDTH-1] of each output, so beat 0 lands at index 0. On error, zeros are written instead.
- DRAIN: captures the last beat. MemRe_SO=0. Goes to RESP.
- RESP: RespValid_SO=3'b111 and all outputs are held stable. When RespReady_SI=1, go to IDLE.
- ReqValid_SI and ReqAddr_DI are ignored outside IDLE. RespReady_SI is ignored outside RESP.
- Data outputs may change during READ/DRAIN and are defined only while RespValid_SO is high. They keep their last value after the handshake.

## Timing
- Reset (asynchronous, while Reset_RI=0): state IDLE; ReqReady_SO=0, RespValid_SO=0, AddrErr_SO=0, MemRe_SO=0, MemAddr_DO=0, all hypervector outputs 0.
- ReqReady_SO is a register. It rises at the first rising edge after Reset_RI goes high.
- Acceptance edge is E0.
  - MemRe_SO is high for cycles E0+1 … E0+BEATS.
  - The last beat is captured at edge E0+BEATS+1.
  - RespValid_SO rises after edge E0+BEATS+2. This gives a latency of BEATS+2 cycles (12 by default).
- Response handshake edge is H. ReqReady_SO is high after H and the next request can be accepted at H+1. With RespReady_SI tied high, throughput is one request per BEATS+4 cycles.
- ReqReady_SO and RespValid_SO are never high in the same cycle.
- Reset asserted mid-READ or mid-RESP: MemRe_SO and RespValid_SO drop immediately (asynchronously). The in-flight request is discarded and no response is ever produced for it.
- Error requests have the same latency as valid requests.

## Test plan
- Macro word at address a*10+k preloaded as {a[7:0], k[7:0], 184'b0} on all three macros; request addr 3 → MemAddr_DO 30..39 on consecutive cycles; RespValid_SO=3'b111 exactly 12 cycles after acceptance; each output slice k = {8'd3, k, 0s}.
- Request addr 255 → MemAddr_DO 2550..2559, no wrap; AddrErr_SO=0.
- Back-pressure: RespReady_SI=0 for 20 cycles, then 1 → outputs stable throughout; ReqReady_SO stays 0 until after the handshake edge; a second ReqValid_SI held high meanwhile is accepted one cycle after the handshake.
- Out of range (NUM_ENTRIES=200, addr 200) → MemRe_SO never asserted; all outputs 0 with AddrErr_SO=1 after 12 cycles; the next valid request clears AddrErr_SO.
- Reset pulsed low at the 5th READ cycle → MemRe_SO=0 and RespValid_SO=0 asynchronously; no response appears; ReqReady_SO=1 one edge after release; a new request completes normally.
- Back-to-back stream of addrs 0,1,2 with RespReady_SI=1 → three responses 14 cycles apart with correct data.

Source files
------------

// File: rtl/hv_sram_server.sv
`default_nettype none
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif
// +----------------------------------------------------------------------------+
// | hv_sram_server                                                             |
// | Reads one IM/neg/pos row over BEATS narrow SRAM beats and returns them as  |
// | three full hypervectors on a valid/ready response.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hv_sram_server #(
    parameter int HV_DIMENSION   = `HV_DIMENSION,
    parameter int WORD_WIDTH     = 200,
    parameter int BEATS          = HV_DIMENSION / WORD_WIDTH,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_ENTRIES    = 256,
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                      Clk_CI,
    input  logic                      Reset_RI,
    input  logic                      ReqValid_SI,
    input  logic [ADDR_WIDTH-1:0]     ReqAddr_DI,
    output logic                      ReqReady_SO,
    input  logic                      RespReady_SI,
    output logic [2:0]                RespValid_SO,
    output logic [0:HV_DIMENSION-1]   IMOut_DO,
    output logic [0:HV_DIMENSION-1]   ProjNeg_DO,
    output logic [0:HV_DIMENSION-1]   ProjPos_DO,
    output logic                      AddrErr_SO,
    output logic                      MemRe_SO,
    output logic [MEM_ADDR_WIDTH-1:0] MemAddr_DO,
    input  logic [WORD_WIDTH-1:0]     MemIM_DI,
    input  logic [WORD_WIDTH-1:0]     MemNeg_DI,
    input  logic [WORD_WIDTH-1:0]     MemPos_DI
);

    localparam int                        c_KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [c_KW-1:0]           c_K_LAST = c_KW'(BEATS - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] c_BEATS  = MEM_ADDR_WIDTH'(BEATS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [c_KW-1:0]           r_k;
    logic [c_KW-1:0]           r_cap_k;
    logic                      r_cap_vld;
    logic [MEM_ADDR_WIDTH-1:0] r_base;
    logic                      r_err;
    logic                      r_req_rdy;
    logic                      r_resp_vld;
    logic                      r_mem_re;
    logic [0:HV_DIMENSION-1]   r_im;
    logic [0:HV_DIMENSION-1]   r_neg;
    logic [0:HV_DIMENSION-1]   r_pos;

    logic                      w_accept;
    logic                      w_addr_err;
    logic                      w_err_nxt;
    int                        w_cap_base;

    assign w_accept   = (r_state == S_IDLE) && ReqValid_SI && r_req_rdy;
    assign w_addr_err = int'(ReqAddr_DI) >= NUM_ENTRIES;
    assign w_err_nxt  = w_accept ? w_addr_err : r_err;
    assign w_cap_base = int'(r_cap_k) * WORD_WIDTH;

    // DRAIN holds until the one-cycle read-data pipeline has delivered its last beat.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)          w_next = S_READ;
            S_READ:  if (r_k == c_K_LAST)   w_next = S_DRAIN;
            S_DRAIN: if (!r_cap_vld)        w_next = S_RESP;
            S_RESP:  if (RespReady_SI)      w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_cap_k    <= '0;
            r_cap_vld  <= 1'b0;
            r_base     <= '0;
            r_err      <= 1'b0;
            r_req_rdy  <= 1'b0;
            r_resp_vld <= 1'b0;
            r_mem_re   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_req_rdy  <= (w_next == S_IDLE);
            r_resp_vld <= (w_next == S_RESP);
            r_mem_re   <= (w_next == S_READ) && !w_err_nxt;
            r_err      <= w_err_nxt;
            r_cap_vld  <= (r_state == S_READ);
            r_cap_k    <= r_k;
            if (w_accept) begin
                r_base <= MEM_ADDR_WIDTH'(ReqAddr_DI) * c_BEATS;
            end
            if ((r_state == S_READ) && (r_k != c_K_LAST)) begin
                r_k <= r_k + 1'b1;
            end else begin
                r_k <= '0;
            end
        end
    end

    // Beat k lands at ascending index k*WORD_WIDTH; error rows are filled with zeros.
    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            r_im  <= '0;
            r_neg <= '0;
            r_pos <= '0;
        end else if (r_cap_vld) begin
            r_im[w_cap_base +: WORD_WIDTH]  <= r_err ? '0 : MemIM_DI;
            r_neg[w_cap_base +: WORD_WIDTH] <= r_err ? '0 : MemNeg_DI;
            r_pos[w_cap_base +: WORD_WIDTH] <= r_err ? '0 : MemPos_DI;
        end
    end

    assign ReqReady_SO  = r_req_rdy;
    assign RespValid_SO = {3{r_resp_vld}};
    assign AddrErr_SO   = r_err;
    assign MemRe_SO     = r_mem_re;
    assign MemAddr_DO   = r_base + MEM_ADDR_WIDTH'(r_k);
    assign IMOut_DO     = r_im;
    assign ProjNeg_DO   = r_neg;
    assign ProjPos_DO   = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_hv_sram_server.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hv_sram_server                                                          |
// | Randomised scoreboard bench for hv_sram_server with an SRAM macro model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hv_sram_server;
    localparam int HV    = 2000;
    localparam int W     = 200;
    localparam int BEATS = 10;
    localparam int AW    = 9;
    localparam int NE    = 300;
    localparam int MAW   = 12;
    localparam int LAT   = BEATS + 2;

    logic            Clk_CI = 1'b0;
    logic            Reset_RI;
    logic            ReqValid_SI;
    logic [AW-1:0]   ReqAddr_DI;
    logic            ReqReady_SO;
    logic            RespReady_SI;
    logic [2:0]      RespValid_SO;
    logic [0:HV-1]   IMOut_DO, ProjNeg_DO, ProjPos_DO;
    logic            AddrErr_SO;
    logic            MemRe_SO;
    logic [MAW-1:0]  MemAddr_DO;
    logic [W-1:0]    MemIM_DI, MemNeg_DI, MemPos_DI;

    typedef struct {
        logic          err;
        logic [0:HV-1] im;
        logic [0:HV-1] neg;
        logic [0:HV-1] pos;
        int            acc;
    } resp_t;

    resp_t          resp_q[$];
    logic [MAW-1:0] addr_q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  bp_left = 0;
    bit  rr_rand = 1'b0;
    bit  chk_gap = 1'b0;
    int  last_rise = -1;
    bit  prev_vld = 1'b0;
    bit  hs_seen = 1'b0;

    hv_sram_server #(
        .HV_DIMENSION  (HV),
        .WORD_WIDTH    (W),
        .BEATS         (BEATS),
        .ADDR_WIDTH    (AW),
        .NUM_ENTRIES   (NE),
        .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .Clk_CI      (Clk_CI),
        .Reset_RI    (Reset_RI),
        .ReqValid_SI (ReqValid_SI),
        .ReqAddr_DI  (ReqAddr_DI),
        .ReqReady_SO (ReqReady_SO),
        .RespReady_SI(RespReady_SI),
        .RespValid_SO(RespValid_SO),
        .IMOut_DO    (IMOut_DO),
        .ProjNeg_DO  (ProjNeg_DO),
        .ProjPos_DO  (ProjPos_DO),
        .AddrErr_SO  (AddrErr_SO),
        .MemRe_SO    (MemRe_SO),
        .MemAddr_DO  (MemAddr_DO),
        .MemIM_DI    (MemIM_DI),
        .MemNeg_DI   (MemNeg_DI),
        .MemPos_DI   (MemPos_DI)
    );

    always #5 Clk_CI = ~Clk_CI;
    always @(posedge Clk_CI) cyc <= cyc + 1;

    // Preloaded macro contents: distinct per macro and per word address.
    function automatic logic [W-1:0] word(input int m, input int a);
        logic [7:0] b;
        b = 8'(a) ^ 8'(m * 90);
        return {12'(a), 4'(m), {23{b}}};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Read data appears the cycle after a read; otherwise the macro outputs garbage.
    always @(posedge Clk_CI) begin
        if (MemRe_SO) begin
            MemIM_DI  <= word(0, int'(MemAddr_DO));
            MemNeg_DI <= word(1, int'(MemAddr_DO));
            MemPos_DI <= word(2, int'(MemAddr_DO));
        end else begin
            MemIM_DI  <= rnd_word();
            MemNeg_DI <= rnd_word();
            MemPos_DI <= rnd_word();
        end
    end

    function automatic resp_t model(input int a, input int acc);
        resp_t r;
        r.err = (a >= NE);
        r.acc = acc;
        r.im  = '0;
        r.neg = '0;
        r.pos = '0;
        if (!r.err) begin
            for (int k = 0; k < BEATS; k++) begin
                r.im[k*W +: W]  = word(0, a * BEATS + k);
                r.neg[k*W +: W] = word(1, a * BEATS + k);
                r.pos[k*W +: W] = word(2, a * BEATS + k);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    task automatic chk_hv(input string nm, input logic [0:HV-1] act, input logic [0:HV-1] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            for (int k = 0; k < BEATS; k++) begin
                if (act[k*W +: W] !== exp[k*W +: W]) begin
                    $display("FAIL %s beat %0d: got %h want %h", nm, k, act[k*W +: W], exp[k*W +: W]);
                    break;
                end
            end
        end
    endtask

    task automatic issue(input int a);
        int n;
        @(negedge Clk_CI);
        ReqValid_SI = 1'b1;
        ReqAddr_DI  = AW'(a);
        for (n = 0; n < 200 && !ReqReady_SO; n++) @(negedge Clk_CI);
        if (!ReqReady_SO) begin
            fail("req_accept_timeout");
            ReqValid_SI = 1'b0;
            return;
        end
        resp_q.push_back(model(a, cyc + 1));
        if (a < NE) begin
            for (int k = 0; k < BEATS; k++) addr_q.push_back(MAW'(a * BEATS + k));
        end
        @(posedge Clk_CI);
    endtask

    task automatic idle();
        @(negedge Clk_CI);
        ReqValid_SI = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 400 && resp_q.size() != 0; n++) @(negedge Clk_CI);
        if (resp_q.size() != 0) begin
            fail("drain_timeout");
            resp_q.delete();
        end
        repeat (2) @(negedge Clk_CI);
    endtask

    initial begin
        RespReady_SI = 1'b1;
        forever begin
            @(posedge Clk_CI);
            #2;
            if (bp_left > 0) begin
                RespReady_SI = 1'b0;
                bp_left--;
            end else begin
                RespReady_SI = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: protocol rules, read-address stream and response scoreboard.
    initial forever begin
        @(negedge Clk_CI);
        if (!Reset_RI) begin
            prev_vld = 1'b0;
            hs_seen  = 1'b0;
        end else begin
            if (hs_seen) chk("ready_after_handshake", ReqReady_SO, 1);
            hs_seen = 1'b0;
            chk("resp_valid_bits", RespValid_SO, (|RespValid_SO) ? 3'b111 : 3'b000);
            chk("ready_valid_exclusive", ReqReady_SO & (|RespValid_SO), 0);
            if (MemRe_SO) begin
                if (addr_q.size() == 0) fail("unexpected_mem_read");
                else chk("mem_addr", MemAddr_DO, addr_q.pop_front());
            end
            if (RespValid_SO[0]) begin
                if (resp_q.size() == 0) begin
                    fail("unexpected_response");
                end else begin
                    if (!prev_vld) begin
                        chk("latency", cyc - resp_q[0].acc, LAT);
                        if (chk_gap && last_rise >= 0) chk("stream_gap", cyc - last_rise, BEATS + 4);
                        last_rise = cyc;
                    end
                    chk("addr_err", AddrErr_SO, resp_q[0].err);
                    chk_hv("im_out", IMOut_DO, resp_q[0].im);
                    chk_hv("proj_neg", ProjNeg_DO, resp_q[0].neg);
                    chk_hv("proj_pos", ProjPos_DO, resp_q[0].pos);
                    if (RespReady_SI) begin
                        void'(resp_q.pop_front());
                        hs_seen = 1'b1;
                    end
                end
            end
            prev_vld = RespValid_SO[0];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_RI    = 1'b1;
        ReqValid_SI = 1'b0;
        ReqAddr_DI  = '0;
        #3 Reset_RI = 1'b0;
        repeat (3) @(negedge Clk_CI);
        chk("rst_req_ready", ReqReady_SO, 0);
        chk("rst_resp_valid", RespValid_SO, 0);
        chk("rst_addr_err", AddrErr_SO, 0);
        chk("rst_mem_re", MemRe_SO, 0);
        chk("rst_mem_addr", MemAddr_DO, 0);
        chk_hv("rst_im", IMOut_DO, '0);
        chk_hv("rst_neg", ProjNeg_DO, '0);
        chk_hv("rst_pos", ProjPos_DO, '0);
        Reset_RI = 1'b1;
        #1 chk("ready_before_first_edge", ReqReady_SO, 0);
        @(negedge Clk_CI);
        chk("ready_after_first_edge", ReqReady_SO, 1);

        issue(3);      idle(); drain();
        issue(255);    idle(); drain();
        issue(NE - 1); idle(); drain();

        // Back-pressure with a second request held during the stall.
        bp_left = 40;
        issue(10); issue(11); idle(); drain();

        // Out-of-range rows, each followed by a valid one.
        issue(NE);  issue(5); idle(); drain();
        issue(511); issue(0); idle(); drain();

        // Reset in the fifth READ cycle discards the in-flight request.
        issue(7); idle();
        repeat (4) @(posedge Clk_CI);
        #2 chk("mem_re_before_reset", MemRe_SO, 1);
        Reset_RI = 1'b0;
        #1;
        chk("mem_re_async_reset", MemRe_SO, 0);
        chk("resp_valid_async_reset", RespValid_SO, 0);
        chk("ready_async_reset", ReqReady_SO, 0);
        resp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge Clk_CI);
        Reset_RI = 1'b1;
        #1 chk("ready_after_release", ReqReady_SO, 0);
        @(negedge Clk_CI);
        chk("ready_one_edge_after_release", ReqReady_SO, 1);
        repeat (30) @(negedge Clk_CI);
        issue(8); idle(); drain();

        last_rise = -1;
        chk_gap   = 1'b1;
        issue(0); issue(1); issue(2); idle(); drain();
        chk_gap   = 1'b0;

        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(0, NE + 19)));
            if ($urandom_range(0, 1) == 1) begin
                idle();
                repeat ($urandom_range(0, 3)) @(negedge Clk_CI);
            end
        end
        idle();
        drain();
        rr_rand = 1'b0;

        chk("resp_queue_empty", resp_q.size(), 0);
        chk("addr_queue_empty", addr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
